// File: rtl/sync_updown_counter_n.sv
// Parametrised synchronous up/down counter with load, wrap/saturate,
// terminal-count and wrap-event flags; cascadable via tc -> en.
//
// Ports:
//   clk   in  1      rising-edge clock
//   clr   in  1      asynchronous reset, active-high (q=0, wrap=0)
//   en    in  1      count enable (0 = hold)
//   m     in  1      direction: 0 = up, 1 = down
//   load  in  1      synchronous parallel load of d (clamped to MODULUS-1)
//   d     in  WIDTH  load value
//   q     out WIDTH  registered count, always in 0..MODULUS-1
//   tc    out 1      combinational terminal count, feeds next stage en
//   wrap  out 1      registered pulse: the last edge hit a range end
module sync_updown_counter_n #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             m,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_cfg
    $error("sync_updown_counter_n: illegal WIDTH/MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);
  localparam bit               SAT   = (SATURATE != 0);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_end;

  // Range end in the current direction: top when counting up,
  // zero when counting down.
  assign at_end = m ? (cnt_q == '0) : (cnt_q == MAX);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      // Out-of-range load values clamp so q never leaves 0..MODULUS-1.
      if ({1'b0, d} >= MOD_X) begin
        cnt_d = MAX;
      end else begin
        cnt_d = d;
      end
    end else if (en) begin
      wrap_d = at_end;
      if (at_end) begin
        if (!SAT) begin
          cnt_d = m ? MAX : '0;
        end
      end else begin
        cnt_d = m ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = cnt_q;
  assign wrap = wrap_q;
  assign tc   = en & ~load & at_end;

endmodule

// File: tb/tb_sync_updown_counter_n.sv
// Bench for sync_updown_counter_n: wrap (M=6), saturate (M=8),
// and a two-stage decade cascade, against an arithmetic model.
module tb_sync_updown_counter_n;

  logic clk;
  int   errors;
  int   checks;

  logic       a_clr, a_en, a_m, a_load, a_tc, a_w;
  logic [2:0] a_d, a_q;
  logic       b_clr, b_en, b_m, b_load, b_tc, b_w;
  logic [2:0] b_d, b_q;
  logic       c_clr, c_en, c_m, c_load;
  logic [3:0] c_dlo, c_dhi, c_qlo, c_qhi;
  logic       c_tclo, c_tchi, c_wlo, c_whi;

  sync_updown_counter_n #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u_a (
    .clk(clk), .clr(a_clr), .en(a_en), .m(a_m), .load(a_load),
    .d(a_d), .q(a_q), .tc(a_tc), .wrap(a_w)
  );

  sync_updown_counter_n #(.WIDTH(3), .MODULUS(8), .SATURATE(1)) u_b (
    .clk(clk), .clr(b_clr), .en(b_en), .m(b_m), .load(b_load),
    .d(b_d), .q(b_q), .tc(b_tc), .wrap(b_w)
  );

  sync_updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
    .clk(clk), .clr(c_clr), .en(c_en), .m(c_m), .load(c_load),
    .d(c_dlo), .q(c_qlo), .tc(c_tclo), .wrap(c_wlo)
  );

  sync_updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
    .clk(clk), .clr(c_clr), .en(c_tclo), .m(c_m), .load(c_load),
    .d(c_dhi), .q(c_qhi), .tc(c_tchi), .wrap(c_whi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit en;
    bit m;
    bit ld;
    int d;
    int tc;
    int q;
    int w;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Next state from the counting rules, in plain integer arithmetic.
  task automatic ref_step(input int q, input bit en, input bit m,
                          input bit ld, input int d, input int mod,
                          input bit sat, output int nq, output bit nw);
    int t;
    nq = q;
    nw = 1'b0;
    if (ld) begin
      nq = (d >= mod) ? mod - 1 : d;
    end else if (en) begin
      t = m ? q - 1 : q + 1;
      if (t < 0 || t >= mod) begin
        nw = 1'b1;
        nq = sat ? q : (t + mod) % mod;
      end else begin
        nq = t;
      end
    end
  endtask

  function automatic int ref_tc(int q, bit en, bit m, bit ld, int mod);
    return int'(en && !ld && (m ? (q == 0) : (q == mod - 1)));
  endfunction

  task automatic sa(input string nm, input bit en, input bit m,
                    input bit ld, input int d, input int etc_,
                    input int eq, input int ew);
    a_en = en; a_m = m; a_load = ld; a_d = 3'(d);
    #1;
    chk({nm, "_tc"}, a_tc, etc_);
    @(posedge clk); #1;
    chk({nm, "_q"}, a_q, eq);
    chk({nm, "_wrap"}, a_w, ew);
  endtask

  task automatic sb(input string nm, input bit en, input bit m,
                    input bit ld, input int d, input int etc_,
                    input int eq, input int ew);
    b_en = en; b_m = m; b_load = ld; b_d = 3'(d);
    #1;
    chk({nm, "_tc"}, b_tc, etc_);
    @(posedge clk); #1;
    chk({nm, "_q"}, b_q, eq);
    chk({nm, "_wrap"}, b_w, ew);
  endtask

  initial begin
    int  ra_q, rb_q, hw, lw, cnt;
    bit  ra_w, rb_w;

    errors = 0;
    checks = 0;
    // en, m, ld, d, tc, q, wrap (M=6 wrap instance, from q=0)
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 2, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 3, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 4, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 5, 0};
    tbl[5]  = '{1, 0, 0, 0, 1, 0, 1};
    tbl[6]  = '{1, 0, 0, 0, 0, 1, 0};
    tbl[7]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 1, 5, 1};
    tbl[9]  = '{1, 1, 0, 0, 0, 4, 0};
    tbl[10] = '{0, 1, 0, 0, 0, 4, 0};
    tbl[11] = '{1, 0, 1, 3, 0, 3, 0};
    tbl[12] = '{1, 0, 1, 7, 0, 5, 0};
    tbl[13] = '{1, 0, 0, 0, 1, 0, 1};
    tbl[14] = '{1, 1, 1, 4, 0, 4, 0};
    tbl[15] = '{0, 0, 1, 6, 0, 5, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 5, 0};

    a_clr = 1; a_en = 0; a_m = 0; a_load = 0; a_d = 0;
    b_clr = 1; b_en = 0; b_m = 0; b_load = 0; b_d = 0;
    c_clr = 1; c_en = 0; c_m = 0; c_load = 0; c_dlo = 0; c_dhi = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_q", a_q, 0);
    chk("rst_a_wrap", a_w, 0);
    chk("rst_b_q", b_q, 0);
    chk("rst_b_wrap", b_w, 0);
    chk("rst_c_q", {c_qhi, c_qlo}, 0);
    a_clr = 0;
    b_clr = 0;

    // Asynchronous clear mid-count, then held for three edges.
    sa("rst_ld", 0, 0, 1, 5, 0, 5, 0);
    a_en = 1; a_load = 0;
    #2 a_clr = 1;
    #1;
    chk("rst_async_q", a_q, 0);
    chk("rst_async_wrap", a_w, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold_q", a_q, 0);
    end
    a_clr = 0;
    @(posedge clk); #1;
    chk("rst_release_q", a_q, 1);

    a_clr = 1;
    #1 a_clr = 0;
    for (int i = 0; i < 17; i++) begin
      sa($sformatf("tbl%0d", i), tbl[i].en, tbl[i].m, tbl[i].ld,
         tbl[i].d, tbl[i].tc, tbl[i].q, tbl[i].w);
    end

    // Saturating instance: hold at both ends with repeated wrap.
    sb("sat_ld", 1, 0, 1, 6, 0, 6, 0);
    sb("sat_up0", 1, 0, 0, 0, 0, 7, 0);
    sb("sat_up1", 1, 0, 0, 0, 1, 7, 1);
    sb("sat_up2", 1, 0, 0, 0, 1, 7, 1);
    sb("sat_up3", 1, 0, 0, 0, 1, 7, 1);
    sb("sat_dn0", 1, 1, 0, 0, 0, 6, 0);
    sb("sat_dn1", 1, 1, 0, 0, 0, 5, 0);
    sb("sat_ld7", 0, 0, 1, 7, 0, 7, 0);
    sb("sat_top", 1, 0, 0, 0, 1, 7, 1);
    b_clr = 1;
    #1;
    chk("sat_clr_q", b_q, 0);
    chk("sat_clr_wrap", b_w, 0);
    b_clr = 0;
    sb("sat_bot", 1, 1, 0, 0, 1, 0, 1);
    sb("sat_idle", 0, 1, 0, 0, 0, 0, 0);

    // Random stimulus against the arithmetic model.
    ra_q = 0; ra_w = 0; rb_q = 0; rb_w = 0;
    for (int it = 0; it < 300; it++) begin
      a_clr = (it == 0) || ($urandom_range(0, 39) == 0);
      a_en = 1'($urandom); a_m = 1'($urandom);
      a_load = ($urandom_range(0, 7) == 0);
      a_d = 3'($urandom_range(0, 7));
      b_clr = (it == 0) || ($urandom_range(0, 39) == 0);
      b_en = 1'($urandom); b_m = 1'($urandom);
      b_load = ($urandom_range(0, 7) == 0);
      b_d = 3'($urandom_range(0, 7));
      if (a_clr) begin ra_q = 0; ra_w = 0; end
      if (b_clr) begin rb_q = 0; rb_w = 0; end
      #1;
      chk("rnd_a_pre_q", a_q, ra_q);
      chk("rnd_a_tc", a_tc, ref_tc(ra_q, a_en, a_m, a_load, 6));
      chk("rnd_b_pre_q", b_q, rb_q);
      chk("rnd_b_tc", b_tc, ref_tc(rb_q, b_en, b_m, b_load, 8));
      @(posedge clk);
      if (!a_clr)
        ref_step(ra_q, a_en, a_m, a_load, int'(a_d), 6, 0, ra_q, ra_w);
      if (!b_clr)
        ref_step(rb_q, b_en, b_m, b_load, int'(b_d), 8, 1, rb_q, rb_w);
      #1;
      chk("rnd_a_q", a_q, ra_q);
      chk("rnd_a_wrap", a_w, ra_w);
      chk("rnd_b_q", b_q, rb_q);
      chk("rnd_b_wrap", b_w, rb_w);
    end
    a_clr = 0;
    b_clr = 0;

    // Two-stage decade cascade: 100 up edges return to 00.
    c_clr = 0;
    c_en = 1;
    hw = 0;
    lw = 0;
    for (int i = 1; i <= 100; i++) begin
      #1;
      chk("casc_tchi", c_tchi, int'((i - 1) == 99));
      @(posedge clk); #1;
      if (c_whi) hw++;
      if (c_wlo) lw++;
      cnt = int'(c_qhi) * 10 + int'(c_qlo);
      chk("casc_cnt", cnt, i % 100);
    end
    chk("casc_hi_wraps", hw, 1);
    chk("casc_lo_wraps", lw, 10);
    chk("casc_end", {c_qhi, c_qlo}, 0);

    c_en = 0; c_load = 1; c_dhi = 4; c_dlo = 2;
    @(posedge clk); #1;
    chk("casc_ld42", int'(c_qhi) * 10 + int'(c_qlo), 42);
    c_load = 0; c_en = 1; c_m = 1;
    for (int i = 41; i >= 39; i--) begin
      @(posedge clk); #1;
      chk("casc_down", int'(c_qhi) * 10 + int'(c_qlo), i);
    end
    c_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
